// File: rtl/square_plotter_if.sv
// Request/pixel-stream bundle between a drawing client and the square plotter.
interface square_plotter_if;
    logic       start;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_color;
    logic       busy;
    logic       done;
    logic       plot;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_color;

    modport master (
        output start, in_x, in_y, in_color,
        input  busy, done, plot, out_x, out_y, out_color
    );

    modport slave (
        input  start, in_x, in_y, in_color,
        output busy, done, plot, out_x, out_y, out_color
    );
endinterface

// File: rtl/square_plotter.sv
// Square rasteriser: emits a SIZE x SIZE filled square one pixel per clock in
// raster order; off-screen pixels are clipped but still occupy their cycle.
module square_plotter #(
    parameter int SIZE     = 16,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic            clock,
    input  logic            reset_n,
    square_plotter_if.slave bus
);
    localparam int            CW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST  = CW'(SIZE - 1);
    localparam logic [8:0]    X_LIM = 9'(SCREEN_W);
    localparam logic [7:0]    Y_LIM = 8'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t        state_q, state_d;
    logic          accept;
    logic          last_px;
    logic [CW-1:0] cx_p0, cy_p0;
    logic [7:0]    base_x_p0;
    logic [6:0]    base_y_p0;
    logic [2:0]    base_color_p0;
    logic [8:0]    sum_x;
    logic [7:0]    sum_y;

    logic          vld_p1;
    logic          done_p1;
    logic          busy_p1;
    logic [7:0]    x_p1;
    logic [6:0]    y_p1;
    logic [2:0]    color_p1;

    function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
        return (sx < X_LIM) && (sy < Y_LIM);
    endfunction

    assign last_px = (cx_p0 == LAST) && (cy_p0 == LAST);
    assign sum_x   = {1'b0, base_x_p0} + 9'(cx_p0);
    assign sum_y   = {1'b0, base_y_p0} + 8'(cy_p0);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = DRAW;
                end
            end
            DRAW:    if (last_px) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: FSM, request capture and raster counters
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cx_p0         <= '0;
            cy_p0         <= '0;
            base_x_p0     <= '0;
            base_y_p0     <= '0;
            base_color_p0 <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                base_x_p0     <= bus.in_x;
                base_y_p0     <= bus.in_y;
                base_color_p0 <= bus.in_color;
                cx_p0         <= '0;
                cy_p0         <= '0;
            end else if (state_q == DRAW) begin
                if (cx_p0 == LAST) begin
                    cx_p0 <= '0;
                    cy_p0 <= cy_p0 + CW'(1);
                end else begin
                    cx_p0 <= cx_p0 + CW'(1);
                end
            end
        end
    end

    // Stage p1: registered pixel stream and status, one cycle behind the FSM
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
            busy_p1  <= 1'b0;
            x_p1     <= '0;
            y_p1     <= '0;
            color_p1 <= '0;
        end else begin
            vld_p1   <= (state_q == DRAW) && on_screen(sum_x, sum_y);
            done_p1  <= (state_q == DONE);
            busy_p1  <= (state_q != IDLE);
            x_p1     <= sum_x[7:0];
            y_p1     <= sum_y[6:0];
            color_p1 <= base_color_p0;
        end
    end

    assign bus.plot      = vld_p1;
    assign bus.done      = done_p1;
    assign bus.busy      = busy_p1;
    assign bus.out_x     = x_p1;
    assign bus.out_y     = y_p1;
    assign bus.out_color = color_p1;
endmodule

// File: tb/tb_square_plotter.sv
// Directed bench for square_plotter at SIZE=4, 2 and 1 sharing one clock/reset.
module tb_square_plotter;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    square_plotter_if b4 ();
    square_plotter_if b2 ();
    square_plotter_if b1 ();

    square_plotter #(.SIZE(4), .SCREEN_W(160), .SCREEN_H(120)) u4 (
        .clock(clock), .reset_n(reset_n), .bus(b4.slave));
    square_plotter #(.SIZE(2), .SCREEN_W(160), .SCREEN_H(120)) u2 (
        .clock(clock), .reset_n(reset_n), .bus(b2.slave));
    square_plotter #(.SIZE(1), .SCREEN_W(160), .SCREEN_H(120)) u1 (
        .clock(clock), .reset_n(reset_n), .bus(b1.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int xb [2];
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        b4.start = 0; b4.in_x = 0; b4.in_y = 0; b4.in_color = 0;
        b2.start = 0; b2.in_x = 0; b2.in_y = 0; b2.in_color = 0;
        b1.start = 0; b1.in_x = 0; b1.in_y = 0; b1.in_color = 0;
        step();
        step();
        check("rst_busy",  b4.busy, 0);
        check("rst_done",  b4.done, 0);
        check("rst_plot",  b4.plot, 0);
        check("rst_x",     b4.out_x, 0);
        check("rst_y",     b4.out_y, 0);
        check("rst_color", b4.out_color, 0);
        reset_n = 1'b1;
        step();

        // 4x4 square at (10,20), colour 010; in_x poked mid-draw
        b4.in_x = 8'd10; b4.in_y = 7'd20; b4.in_color = 3'b010; b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        check("acc_plot", b4.plot, 0);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) b4.in_x = 8'd99;
            step();
            check("sq_plot",  b4.plot, 1);
            check("sq_x",     b4.out_x, 10 + k % 4);
            check("sq_y",     b4.out_y, 20 + k / 4);
            check("sq_color", b4.out_color, 3'b010);
            check("sq_busy",  b4.busy, 1);
            check("sq_done",  b4.done, 0);
        end
        step();
        check("sq_done_hi", b4.done, 1);
        check("sq_done_pl", b4.plot, 0);
        check("sq_done_bz", b4.busy, 1);
        step();
        check("sq_idle_dn", b4.done, 0);
        check("sq_idle_bz", b4.busy, 0);

        // clipped square at the bottom-right corner
        b4.in_x = 8'd158; b4.in_y = 7'd118; b4.in_color = 3'b101; b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            check("clip_plot", b4.plot, (k % 4 < 2 && k / 4 < 2) ? 1 : 0);
            check("clip_x",    b4.out_x, 158 + k % 4);
            check("clip_y",    b4.out_y, 118 + k / 4);
            check("clip_busy", b4.busy, 1);
        end
        step();
        check("clip_done", b4.done, 1);
        step();
        check("clip_idle", b4.busy, 0);

        // reset after the fifth plotted pixel
        b4.in_x = 8'd30; b4.in_y = 7'd40; b4.in_color = 3'b110; b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("pre_rst_plot", b4.plot, 1);
        end
        reset_n = 1'b0;
        step();
        check("mid_rst_plot",  b4.plot, 0);
        check("mid_rst_busy",  b4.busy, 0);
        check("mid_rst_done",  b4.done, 0);
        check("mid_rst_x",     b4.out_x, 0);
        check("mid_rst_y",     b4.out_y, 0);
        check("mid_rst_color", b4.out_color, 0);
        reset_n = 1'b1;
        b4.in_x = 8'd1; b4.in_y = 7'd2; b4.in_color = 3'b001; b4.start = 1'b1;
        step();
        b4.start = 1'b0;
        check("post_rst_acc", b4.plot, 0);
        for (int k = 0; k < 16; k++) begin
            step();
            check("post_rst_plot", b4.plot, 1);
            check("post_rst_x",    b4.out_x, 1 + k % 4);
            check("post_rst_y",    b4.out_y, 2 + k / 4);
            check("post_rst_col",  b4.out_color, 3'b001);
        end
        step();
        check("post_rst_done", b4.done, 1);
        step();
        check("post_rst_idle", b4.busy, 0);

        // SIZE=2, start held high: 6-cycle period; in_x change applies next square
        xb[0] = 50;
        xb[1] = 70;
        b2.in_x = 8'd50; b2.in_y = 7'd60; b2.in_color = 3'b100; b2.start = 1'b1;
        step();
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < 4; j++) begin
                step();
                check("rep_plot",  b2.plot, 1);
                check("rep_x",     b2.out_x, xb[p] + j % 2);
                check("rep_y",     b2.out_y, 60 + j / 2);
                check("rep_color", b2.out_color, 3'b100);
                if (p == 0 && j == 1) b2.in_x = 8'd70;
            end
            step();
            check("rep_done", b2.done, 1);
            check("rep_dpl",  b2.plot, 0);
            if (p == 1) b2.start = 1'b0;
            step();
            check("rep_gap_bz", b2.busy, 0);
            check("rep_gap_pl", b2.plot, 0);
            check("rep_gap_dn", b2.done, 0);
        end
        step();
        check("rep_stop_bz", b2.busy, 0);
        check("rep_stop_pl", b2.plot, 0);

        // SIZE=1 single pixel at the origin
        b1.in_x = 8'd0; b1.in_y = 7'd0; b1.in_color = 3'b111; b1.start = 1'b1;
        step();
        b1.start = 1'b0;
        step();
        check("one_plot",  b1.plot, 1);
        check("one_x",     b1.out_x, 0);
        check("one_y",     b1.out_y, 0);
        check("one_color", b1.out_color, 3'b111);
        check("one_ndone", b1.done, 0);
        step();
        check("one_done",  b1.done, 1);
        check("one_dpl",   b1.plot, 0);
        step();
        check("one_idle",  b1.busy, 0);
        check("one_dlow",  b1.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
